// File: rtl/sync_multi_bit_filtered.sv
// -----------------------------------------------------------------------------
// sync_multi_bit_filtered
//
// Brings a slow or asynchronous multi-bit bus (ADC codes, switch banks, DDS
// words) into the clk domain. The bus first passes through a plain STAGES-deep
// flop chain. A stability filter then commits a value to sync_out only after
// the synchronised bus has shown that value on STABLE_CYCLES consecutive
// cycles. This rejects torn samples taken while the source bits were still
// changing.
//
// Parameters
//   WIDTH          bus width (>=1)
//   STAGES         synchroniser flops ahead of the filter (>=2)
//   STABLE_CYCLES  consecutive equal samples needed to commit (>=1);
//                  1 disables filtering
//   RESET_VALUE    value loaded into the chain, the candidate and sync_out
//   CNT_WIDTH      width of reject_cnt
//
// Ports
//   clk         in   1          system clock
//   rst         in   1          asynchronous, active-high reset
//   sig_in      in   WIDTH      asynchronous input bus
//   sync_out    out  WIDTH      filtered, synchronised value
//   changed     out  1          one-cycle pulse when sync_out takes a new value
//   stable      out  1          bus equals sync_out and the run is complete
//   reject_cnt  out  CNT_WIDTH  saturating count of abandoned transient values
//   clr_cnt     in   1          synchronous clear of reject_cnt (clk domain)
// -----------------------------------------------------------------------------
module sync_multi_bit_filtered #(
   parameter int                WIDTH         = 12,
   parameter int                STAGES        = 2,
   parameter int                STABLE_CYCLES = 1,
   parameter logic [WIDTH-1:0]  RESET_VALUE   = '0,
   parameter int                CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     sig_in,
   output logic [WIDTH-1:0]     sync_out,
   output logic                 changed,
   output logic                 stable,
   output logic [CNT_WIDTH-1:0] reject_cnt,
   input  logic                 clr_cnt
);

   // Illegal parameter sets are stopped at elaboration.
   if (WIDTH < 1) begin : g_bad_width
      $error("sync_multi_bit_filtered: WIDTH must be >= 1");
   end
   if (STAGES < 2) begin : g_bad_stages
      $error("sync_multi_bit_filtered: STAGES must be >= 2");
   end
   if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("sync_multi_bit_filtered: STABLE_CYCLES must be >= 1");
   end

   // The guard keeps the run counter at a legal width even when the
   // parameter check above is about to reject the configuration.
   localparam int               RUN_W   = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   // ---------------------------------------------------------------------------
   // Synchroniser chain: nothing but flops between stages.
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] r_chain [STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_chain[k] <= RESET_VALUE;
         end
      end else begin
         r_chain[0] <= sig_in;
         for (int k = 1; k < STAGES; k++) begin
            r_chain[k] <= r_chain[k-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stability filter
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0]     r_cand;        // value seen on d last cycle
   logic [RUN_W-1:0]     r_run;         // consecutive cycles r_cand has held
   logic [WIDTH-1:0]     r_sync;
   logic                 r_changed;
   logic                 r_stable;
   logic [CNT_WIDTH-1:0] r_reject_cnt;

   logic [WIDTH-1:0]     w_d;
   logic                 w_same;
   logic [RUN_W-1:0]     w_run_next;
   logic                 w_run_full;
   logic                 w_commit;
   logic [WIDTH-1:0]     w_sync_next;
   logic                 w_stable_next;
   logic                 w_reject;

   always_comb begin
      w_d    = r_chain[STAGES-1];
      w_same = (w_d == r_cand);

      // Run length saturates at STABLE_CYCLES; any new value restarts it at 1.
      w_run_next = RUN_ONE;
      if (w_same) begin
         w_run_next = (r_run >= RUN_MAX) ? RUN_MAX : (r_run + RUN_ONE);
      end
      w_run_full = (w_run_next == RUN_MAX);

      // Returning to the committed value only restarts the run; no commit.
      w_commit      = w_run_full && (w_d != r_sync);
      w_sync_next   = w_commit ? w_d : r_sync;
      w_stable_next = w_run_full && (w_d == w_sync_next);

      // A candidate that differs from sync_out and is abandoned before it
      // completed its run is a rejected transient.
      w_reject = !w_same && (r_cand != r_sync) && (r_run < RUN_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cand       <= RESET_VALUE;
         r_run        <= RUN_MAX;
         r_sync       <= RESET_VALUE;
         r_changed    <= 1'b0;
         r_stable     <= 1'b1;
         r_reject_cnt <= '0;
      end else begin
         r_cand    <= w_d;
         r_run     <= w_run_next;
         r_sync    <= w_sync_next;
         r_changed <= w_commit;
         r_stable  <= w_stable_next;

         // Clear has priority over a same-cycle increment; the count
         // sticks at all-ones rather than wrapping.
         if (clr_cnt) begin
            r_reject_cnt <= '0;
         end else if (w_reject && !(&r_reject_cnt)) begin
            r_reject_cnt <= r_reject_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign sync_out   = r_sync;
   assign changed    = r_changed;
   assign stable     = r_stable;
   assign reject_cnt = r_reject_cnt;

endmodule

// File: tb/tb_sync_multi_bit_filtered.sv
// -----------------------------------------------------------------------------
// tb_sync_multi_bit_filtered
//
// Three instances share clock, reset and input:
//   u_a : defaults (STABLE_CYCLES = 1)
//   u_b : STABLE_CYCLES = 4, CNT_WIDTH = 2
//   u_c : STABLE_CYCLES = 3, RESET_VALUE = 12'h3C3
// Each directed step exercises one instance; the others simply follow along.
// Inputs change 1 time unit after a rising edge, outputs are read there too.
// -----------------------------------------------------------------------------
module tb_sync_multi_bit_filtered;

   logic        clk;
   logic        rst;
   logic [11:0] sig_in;
   logic        clr_cnt;

   logic [11:0] a_sync, b_sync, c_sync;
   logic        a_chg, b_chg, c_chg;
   logic        a_stb, b_stb, c_stb;
   logic [15:0] a_rej;
   logic [1:0]  b_rej;
   logic [15:0] c_rej;

   int n_assert = 0;
   int n_fail   = 0;
   int a_pulses = 0;
   int b_pulses = 0;
   int c_pulses = 0;

   sync_multi_bit_filtered u_a (
      .clk(clk), .rst(rst), .sig_in(sig_in), .sync_out(a_sync), .changed(a_chg),
      .stable(a_stb), .reject_cnt(a_rej), .clr_cnt(clr_cnt)
   );

   sync_multi_bit_filtered #(.WIDTH(12), .STAGES(2), .STABLE_CYCLES(4), .CNT_WIDTH(2)) u_b (
      .clk(clk), .rst(rst), .sig_in(sig_in), .sync_out(b_sync), .changed(b_chg),
      .stable(b_stb), .reject_cnt(b_rej), .clr_cnt(clr_cnt)
   );

   sync_multi_bit_filtered #(.WIDTH(12), .STAGES(2), .STABLE_CYCLES(3),
                             .RESET_VALUE(12'h3C3), .CNT_WIDTH(16)) u_c (
      .clk(clk), .rst(rst), .sig_in(sig_in), .sync_out(c_sync), .changed(c_chg),
      .stable(c_stb), .reject_cnt(c_rej), .clr_cnt(clr_cnt)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_assert++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One rising edge, then settle 1 unit; tally changed pulses per instance.
   task automatic edge1();
      @(posedge clk);
      #1;
      if (a_chg === 1'b1) a_pulses++;
      if (b_chg === 1'b1) b_pulses++;
      if (c_chg === 1'b1) c_pulses++;
   endtask

   task automatic edges(input int n);
      for (int i = 0; i < n; i++) edge1();
   endtask

   // Short asynchronous reset pulse placed between edges.
   task automatic reset_pulse();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   // Transient of 2 sampled cycles on sig_in, then back to 0, then idle.
   // The reject (if any) lands on the 5th edge.
   task automatic transient_0f0();
      sig_in = 12'h0F0;
      edges(2);
      sig_in = 12'h000;
      edges(3);
      edges(5);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst     = 1'b1;
      sig_in  = 12'h000;
      clr_cnt = 1'b0;
      #1;

      // Reset state
      chk("rst_a_sync",   32'(a_sync), 32'h000);
      chk("rst_a_chg",    32'(a_chg),  32'd0);
      chk("rst_a_stable", 32'(a_stb),  32'd1);
      chk("rst_a_rej",    32'(a_rej),  32'd0);
      chk("rst_c_sync",   32'(c_sync), 32'h3C3);
      chk("rst_c_stable", 32'(c_stb),  32'd1);
      edges(2);
      rst = 1'b0;
      edges(10);
      chk("settle_c_sync", 32'(c_sync), 32'h000);
      chk("settle_c_rej",  32'(c_rej),  32'd0);

      // Clean step, defaults: visible after the 3rd edge
      a_pulses = 0;
      sig_in = 12'hABC;
      edges(2);
      chk("a_step_e2_sync", 32'(a_sync), 32'h000);
      edge1();
      chk("a_step_e3_sync", 32'(a_sync), 32'hABC);
      chk("a_step_e3_chg",  32'(a_chg),  32'd1);
      chk("a_step_e3_stb",  32'(a_stb),  32'd1);
      edges(4);
      chk("a_step_chg_cnt", 32'(a_pulses), 32'd1);
      chk("a_step_rej",     32'(a_rej),    32'd0);

      // STABLE_CYCLES = 4 clean step: commit on the 6th edge
      sig_in = 12'h000;
      reset_pulse();
      edges(10);
      b_pulses = 0;
      sig_in = 12'h5A5;
      edges(5);
      chk("b_step_e5_sync", 32'(b_sync), 32'h000);
      chk("b_step_e5_stb",  32'(b_stb),  32'd0);
      edge1();
      chk("b_step_e6_sync", 32'(b_sync), 32'h5A5);
      chk("b_step_e6_chg",  32'(b_chg),  32'd1);
      chk("b_step_e6_stb",  32'(b_stb),  32'd1);
      edge1();
      chk("b_step_e7_chg",  32'(b_chg),  32'd0);
      chk("b_step_e7_stb",  32'(b_stb),  32'd1);
      edges(3);
      chk("b_step_chg_cnt", 32'(b_pulses), 32'd1);
      chk("b_step_rej",     32'(b_rej),    32'd0);

      // STABLE_CYCLES = 4 transient of 2 cycles: rejected on the 5th edge
      sig_in = 12'h000;
      reset_pulse();
      edges(10);
      b_pulses = 0;
      sig_in = 12'h0F0;
      edges(2);
      sig_in = 12'h000;
      edges(2);
      chk("b_tr_e4_rej", 32'(b_rej), 32'd0);
      edge1();
      chk("b_tr_e5_rej", 32'(b_rej), 32'd1);
      edges(8);
      chk("b_tr_sync",    32'(b_sync),   32'h000);
      chk("b_tr_chg_cnt", 32'(b_pulses), 32'd0);
      chk("b_tr_rej",     32'(b_rej),    32'd1);

      // Four more transients: 2, 3, then saturated at 3
      transient_0f0();
      chk("b_sat_2", 32'(b_rej), 32'd2);
      transient_0f0();
      chk("b_sat_3", 32'(b_rej), 32'd3);
      transient_0f0();
      chk("b_sat_4", 32'(b_rej), 32'd3);
      transient_0f0();
      chk("b_sat_5", 32'(b_rej), 32'd3);
      chk("b_sat_sync",    32'(b_sync),   32'h000);
      chk("b_sat_chg_cnt", 32'(b_pulses), 32'd0);

      // Clear for one cycle
      clr_cnt = 1'b1;
      edge1();
      clr_cnt = 1'b0;
      chk("b_clr", 32'(b_rej), 32'd0);

      // Clear on the same edge as a reject: clear wins
      sig_in = 12'h0F0;
      edges(2);
      sig_in = 12'h000;
      edges(2);
      clr_cnt = 1'b1;
      edge1();
      clr_cnt = 1'b0;
      chk("b_clr_wins", 32'(b_rej), 32'd0);
      edges(5);
      chk("b_clr_after", 32'(b_rej), 32'd0);

      // STABLE_CYCLES = 3: 0xFFF for 2 cycles then 0x123 held
      sig_in = 12'h000;
      reset_pulse();
      edges(10);
      chk("c_pre_sync", 32'(c_sync), 32'h000);
      c_pulses = 0;
      sig_in = 12'hFFF;
      edges(2);
      sig_in = 12'h123;
      edges(2);
      chk("c_e4_rej", 32'(c_rej), 32'd0);
      edge1();
      chk("c_e5_rej", 32'(c_rej), 32'd1);
      edge1();
      chk("c_e6_sync", 32'(c_sync), 32'h000);
      edge1();
      chk("c_e7_sync", 32'(c_sync), 32'h123);
      chk("c_e7_chg",  32'(c_chg),  32'd1);
      edges(3);
      chk("c_chg_cnt", 32'(c_pulses), 32'd1);
      chk("c_rej",     32'(c_rej),    32'd1);

      // Asynchronous reset mid-run, between edges
      sig_in = 12'h777;
      edges(3);
      #2;
      rst = 1'b1;
      #1;
      chk("c_arst_sync", 32'(c_sync), 32'h3C3);
      chk("c_arst_chg",  32'(c_chg),  32'd0);
      chk("c_arst_rej",  32'(c_rej),  32'd0);
      chk("c_arst_stb",  32'(c_stb),  32'd1);
      #1;
      rst = 1'b0;
      sig_in = 12'h456;
      c_pulses = 0;
      edges(4);
      chk("c_rel_e4_sync", 32'(c_sync),   32'h3C3);
      chk("c_rel_e4_cnt",  32'(c_pulses), 32'd0);
      edge1();
      chk("c_rel_e5_sync", 32'(c_sync), 32'h456);
      chk("c_rel_e5_chg",  32'(c_chg),  32'd1);
      edges(3);
      chk("c_rel_chg_cnt", 32'(c_pulses), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
